// File: rtl/card_dealer_if.sv
// Card dealer bus: shuffler load port, deal request/response and status.
// master = stimulus / host side, slave = card_dealer.
interface card_dealer_if;
    logic       new_deck;
    logic       load_valid;
    logic [5:0] load_card;
    logic       deal_req;
    logic       deck_ready;
    logic       deal_valid;
    logic [5:0] deal_card;
    logic [3:0] deal_rank;
    logic [1:0] deal_suit;
    logic [3:0] deal_points;
    logic [5:0] cards_left;
    logic       need_shuffle;
    logic       deal_empty;
    logic       load_error;

    modport master (
        output new_deck, load_valid, load_card, deal_req,
        input  deck_ready, deal_valid, deal_card, deal_rank, deal_suit,
               deal_points, cards_left, need_shuffle, deal_empty, load_error
    );

    modport slave (
        input  new_deck, load_valid, load_card, deal_req,
        output deck_ready, deal_valid, deal_card, deal_rank, deal_suit,
               deal_points, cards_left, need_shuffle, deal_empty, load_error
    );
endinterface

// File: rtl/card_dealer.sv
// Card dealer: stores a shuffled deck loaded card by card, then deals it
// back in load order with rank/suit/blackjack-points decode.
// Optional macro DEALER_DUP_CHECK_EN rejects out-of-range and duplicate
// cards during load and raises a sticky load_error.
module card_dealer #(
    parameter int DECK_SIZE    = 52,
    parameter int RESHUFFLE_AT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    card_dealer_if.slave  bus
);
    localparam int PTR_W = $clog2(DECK_SIZE);
    localparam int CNT_W = $clog2(DECK_SIZE + 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DEAL  = 2'd1;
    localparam logic [1:0] ST_EMPTY = 2'd2;

    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DECK_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DECK_SIZE);
    localparam logic [CNT_W-1:0] SHUF_LEVEL = CNT_W'(RESHUFFLE_AT);

    logic [1:0]       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cards_left;
    logic [5:0]       mem [DECK_SIZE];

    logic       deal_valid;
    logic       deal_empty;
    logic [5:0] deal_card;
    logic [3:0] deal_rank;
    logic [1:0] deal_suit;
    logic [3:0] deal_points;
    logic       load_error;
    logic       card_bad;
    logic       load_accept;

    // Rank 1..13 from card code (ace = 1).
    function automatic logic [3:0] card_rank(input logic [5:0] code);
        logic [5:0] r;
        r = code % 6'd13;
        return r[3:0] + 4'd1;
    endfunction

    // Suit 0..3 from card code.
    function automatic logic [1:0] card_suit(input logic [5:0] code);
        logic [5:0] q;
        q = code / 6'd13;
        return q[1:0];
    endfunction

    // Blackjack points: face cards count 10, ace counts 1.
    function automatic logic [3:0] card_points(input logic [3:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

`ifdef DEALER_DUP_CHECK_EN
    logic [DECK_SIZE-1:0] seen;
    logic                 card_dup;
    logic                 card_range_bad;

    // Look the incoming code up in the set of cards already accepted.
    always_comb begin
        card_dup = 1'b0;
        for (int i = 0; i < DECK_SIZE; i++) begin
            if (seen[i] && (bus.load_card == 6'(i))) begin
                card_dup = 1'b1;
            end
        end
    end

    assign card_range_bad = (bus.load_card > 6'd51) || (int'(bus.load_card) >= DECK_SIZE);
    assign card_bad       = card_range_bad || card_dup;

    // Track accepted cards; cleared whenever a new deck starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
        end else if (bus.new_deck) begin
            seen <= '0;
        end else if (load_accept) begin
            for (int i = 0; i < DECK_SIZE; i++) begin
                if (bus.load_card == 6'(i)) begin
                    seen[i] <= 1'b1;
                end
            end
        end
    end

    // Sticky rejection flag, cleared only by a new deck or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_error <= 1'b0;
        end else if (bus.new_deck) begin
            load_error <= 1'b0;
        end else if ((state == ST_LOAD) && bus.load_valid && card_bad) begin
            load_error <= 1'b1;
        end
    end
`else
    assign card_bad   = 1'b0;
    assign load_error = 1'b0;
`endif

    assign load_accept = (state == ST_LOAD) && bus.load_valid && !card_bad && !bus.new_deck;

    // Deck storage; contents are don't-care until rewritten by the next load.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem[wr_ptr] <= bus.load_card;
        end
    end

    // Control FSM, pointers, count and the registered deal outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cards_left  <= '0;
            deal_valid  <= 1'b0;
            deal_empty  <= 1'b0;
            deal_card   <= '0;
            deal_rank   <= '0;
            deal_suit   <= '0;
            deal_points <= '0;
        end else begin
            deal_valid <= 1'b0;
            deal_empty <= 1'b0;
            if (bus.new_deck) begin
                state      <= ST_LOAD;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                cards_left <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (load_accept) begin
                            if (wr_ptr == LAST_IDX) begin
                                state      <= ST_DEAL;
                                cards_left <= FULL_COUNT;
                                rd_ptr     <= '0;
                                wr_ptr     <= '0;
                            end else begin
                                wr_ptr <= wr_ptr + PTR_W'(1);
                            end
                        end
                    end
                    ST_DEAL: begin
                        if (bus.deal_req) begin
                            deal_valid  <= 1'b1;
                            deal_card   <= mem[rd_ptr];
                            deal_rank   <= card_rank(mem[rd_ptr]);
                            deal_suit   <= card_suit(mem[rd_ptr]);
                            deal_points <= card_points(card_rank(mem[rd_ptr]));
                            rd_ptr      <= rd_ptr + PTR_W'(1);
                            cards_left  <= cards_left - CNT_W'(1);
                            if (cards_left == CNT_W'(1)) begin
                                state <= ST_EMPTY;
                            end
                        end
                    end
                    ST_EMPTY: begin
                        if (bus.deal_req) begin
                            deal_empty <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

    assign bus.deck_ready   = (state == ST_DEAL);
    assign bus.need_shuffle = (state == ST_EMPTY) ||
                              ((state == ST_DEAL) && (cards_left <= SHUF_LEVEL));
    assign bus.cards_left   = 6'(cards_left);
    assign bus.deal_valid   = deal_valid;
    assign bus.deal_empty   = deal_empty;
    assign bus.deal_card    = deal_card;
    assign bus.deal_rank    = deal_rank;
    assign bus.deal_suit    = deal_suit;
    assign bus.deal_points  = deal_points;
    assign bus.load_error   = load_error;
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed scenarios plus a random
// traffic run, all checked against a queue-based deck model.
module tb_card_dealer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    card_dealer_if bus();

    card_dealer #(.DECK_SIZE(52), .RESHUFFLE_AT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 = loading, 1 = dealing, 2 = deck exhausted
    int         mode;
    int         deck[$];
    logic [5:0] e_card;
    logic [3:0] e_rank;
    logic [1:0] e_suit;
    logic [3:0] e_points;
    logic       e_valid, e_empty, e_err;

    function automatic bit in_deck(input int c);
        foreach (deck[i]) if (deck[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_ready();
        return (mode == 1);
    endfunction

    function automatic logic [5:0] exp_left();
        return (mode == 0) ? 6'd0 : 6'(deck.size());
    endfunction

    function automatic logic exp_shuffle();
        return (mode == 2) || ((mode == 1) && (deck.size() <= 15));
    endfunction

    task automatic model_reset();
        mode = 0; deck.delete();
        e_card = 0; e_rank = 0; e_suit = 0; e_points = 0;
        e_valid = 0; e_empty = 0; e_err = 0;
    endtask

    task automatic model_step(input bit nd, input bit lv, input int lc, input bit dr);
        int c;
        bit bad;
        e_valid = 0; e_empty = 0;
        if (nd) begin
            mode = 0; deck.delete(); e_err = 0;
        end else if (mode == 0) begin
            if (lv) begin
`ifdef DEALER_DUP_CHECK_EN
                bad = (lc > 51) || in_deck(lc);
`else
                bad = 0;
`endif
                if (bad) e_err = 1;
                else deck.push_back(lc);
                if (deck.size() == 52) mode = 1;
            end
        end else if (mode == 1) begin
            if (dr) begin
                c = deck.pop_front();
                e_valid = 1;
                e_card = 6'(c);
                e_rank = 4'(c % 13 + 1);
                e_suit = 2'(c / 13);
                e_points = (e_rank > 10) ? 4'd10 : e_rank;
                if (deck.size() == 0) mode = 2;
            end
        end else begin
            if (dr) e_empty = 1;
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic do_cycle(input bit nd, input bit lv, input int lc, input bit dr);
        bus.new_deck = nd; bus.load_valid = lv; bus.load_card = 6'(lc); bus.deal_req = dr;
        @(posedge clk); #1;
        bus.new_deck = 0; bus.load_valid = 0; bus.load_card = 0; bus.deal_req = 0;
        model_step(nd, lv, lc, dr);
    endtask

    task automatic assert_reset();
        rst_n = 0; #1;
        model_reset();
    endtask

    task automatic release_reset();
        #2 rst_n = 1;
    endtask

    task automatic load_shuffled();
        int p[52];
        int j, t;
        for (int i = 0; i < 52; i++) p[i] = i;
        for (int i = 51; i > 0; i--) begin
            j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < 52; i++) do_cycle(0, 1, p[i], 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        assert_reset();
        checks++;
        if ({bus.deck_ready, bus.deal_valid, bus.deal_empty, bus.load_error, bus.need_shuffle} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000",
                {bus.deck_ready, bus.deal_valid, bus.deal_empty, bus.load_error, bus.need_shuffle});
        end
        checks++;
        if ({bus.cards_left, bus.deal_card, bus.deal_rank, bus.deal_suit, bus.deal_points} !== 22'd0) begin
            errors++; $display("FAIL reset_data got %h exp 0",
                {bus.cards_left, bus.deal_card, bus.deal_rank, bus.deal_suit, bus.deal_points});
        end
        release_reset();
    endtask

    task automatic test_ordered_deal();
        for (int i = 0; i < 52; i++) begin
            do_cycle(0, 1, i, 0);
            if (i == 50) begin
                checks++;
                if (bus.deck_ready !== 1'b0 || bus.cards_left !== 6'd0) begin
                    errors++; $display("FAIL load_partial ready=%b left=%0d exp 0/0", bus.deck_ready, bus.cards_left);
                end
            end
        end
        checks++;
        if (bus.deck_ready !== 1'b1 || bus.cards_left !== 6'd52) begin
            errors++; $display("FAIL load_full ready=%b left=%0d exp 1/52", bus.deck_ready, bus.cards_left);
        end
        for (int i = 0; i < 52; i++) begin
            do_cycle(0, 0, 0, 1);
            checks++;
            if (bus.deal_valid !== 1'b1 || bus.deal_card !== 6'(i)) begin
                errors++; $display("FAIL ordered_deal valid=%b card=%0d exp 1/%0d", bus.deal_valid, bus.deal_card, i);
            end
            checks++;
            if ({bus.deal_rank, bus.deal_suit, bus.deal_points} !== {e_rank, e_suit, e_points}) begin
                errors++; $display("FAIL deal_decode card %0d got r%0d s%0d p%0d exp r%0d s%0d p%0d", i,
                    bus.deal_rank, bus.deal_suit, bus.deal_points, e_rank, e_suit, e_points);
            end
            if (i == 13 || i == 51) begin
                checks++;
                if ({bus.deal_rank, bus.deal_suit, bus.deal_points} !== ((i == 13) ? {4'd1, 2'd1, 4'd1} : {4'd13, 2'd3, 4'd10})) begin
                    errors++; $display("FAIL corner_card %0d got r%0d s%0d p%0d", i,
                        bus.deal_rank, bus.deal_suit, bus.deal_points);
                end
            end
            checks++;
            if (bus.cards_left !== exp_left() || bus.need_shuffle !== exp_shuffle()) begin
                errors++; $display("FAIL deal_status left=%0d shuf=%b exp %0d/%b",
                    bus.cards_left, bus.need_shuffle, exp_left(), exp_shuffle());
            end
            if (i % 8 == 3) begin
                do_cycle(0, 0, 0, 0);
                checks++;
                if (bus.deal_valid !== 1'b0 || bus.deal_card !== 6'(i)) begin
                    errors++; $display("FAIL deal_hold valid=%b card=%0d exp 0/%0d", bus.deal_valid, bus.deal_card, i);
                end
            end
        end
        do_cycle(0, 0, 0, 1);
        checks++;
        if ({bus.deal_empty, bus.deal_valid, bus.deck_ready, bus.need_shuffle} !== 4'b1001 || bus.deal_card !== 6'd51) begin
            errors++; $display("FAIL empty_deal emp/val/rdy/shuf=%b card=%0d exp 1001/51",
                {bus.deal_empty, bus.deal_valid, bus.deck_ready, bus.need_shuffle}, bus.deal_card);
        end
        do_cycle(0, 0, 0, 0);
        checks++;
        if (bus.deal_empty !== 1'b0) begin
            errors++; $display("FAIL empty_pulse got %b exp 0", bus.deal_empty);
        end
    endtask

    task automatic test_threshold();
        do_cycle(1, 0, 0, 0);
        load_shuffled();
        for (int i = 0; i < 36; i++) do_cycle(0, 0, 0, 1);
        checks++;
        if (bus.cards_left !== 6'd16 || bus.need_shuffle !== 1'b0) begin
            errors++; $display("FAIL thresh_36 left=%0d shuf=%b exp 16/0", bus.cards_left, bus.need_shuffle);
        end
        do_cycle(0, 0, 0, 1);
        checks++;
        if (bus.cards_left !== 6'd15 || bus.need_shuffle !== 1'b1 || bus.deal_card !== e_card) begin
            errors++; $display("FAIL thresh_37 left=%0d shuf=%b card=%0d exp 15/1/%0d",
                bus.cards_left, bus.need_shuffle, bus.deal_card, e_card);
        end
    endtask

    task automatic test_new_deck_mid_deal();
        do_cycle(1, 0, 0, 0);
        load_shuffled();
        for (int i = 0; i < 22; i++) do_cycle(0, 0, 0, 1);
        checks++;
        if (bus.cards_left !== 6'd30) begin
            errors++; $display("FAIL mid_deal_left got %0d exp 30", bus.cards_left);
        end
        do_cycle(1, 0, 0, 1);
        checks++;
        if ({bus.deal_valid, bus.deal_empty, bus.deck_ready} !== 3'b000 || bus.cards_left !== 6'd0) begin
            errors++; $display("FAIL new_deck_wins val/emp/rdy=%b left=%0d exp 000/0",
                {bus.deal_valid, bus.deal_empty, bus.deck_ready}, bus.cards_left);
        end
        do_cycle(0, 0, 0, 1);
        checks++;
        if ({bus.deal_valid, bus.deal_empty} !== 2'b00) begin
            errors++; $display("FAIL deal_in_load val/emp=%b exp 00", {bus.deal_valid, bus.deal_empty});
        end
        do_cycle(1, 1, 7, 0);
        load_shuffled();
        checks++;
        if (bus.deck_ready !== 1'b1 || bus.cards_left !== 6'd52) begin
            errors++; $display("FAIL reload ready=%b left=%0d exp 1/52", bus.deck_ready, bus.cards_left);
        end
        do_cycle(0, 1, 9, 0);
        checks++;
        if (bus.cards_left !== 6'd52) begin
            errors++; $display("FAIL load_in_deal left=%0d exp 52", bus.cards_left);
        end
        do_cycle(0, 0, 0, 1);
        checks++;
        if (bus.deal_card !== e_card || bus.deal_valid !== 1'b1) begin
            errors++; $display("FAIL first_after_reload card=%0d valid=%b exp %0d/1", bus.deal_card, bus.deal_valid, e_card);
        end
    endtask

    task automatic test_reset_mid_load();
        do_cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) do_cycle(0, 1, $urandom_range(0, 51), 0);
        assert_reset();
        checks++;
        if ({bus.deck_ready, bus.deal_valid, bus.deal_empty, bus.load_error, bus.need_shuffle, bus.cards_left, bus.deal_card} !== 17'd0) begin
            errors++; $display("FAIL reset_mid_load got %h exp 0",
                {bus.deck_ready, bus.deal_valid, bus.deal_empty, bus.load_error, bus.need_shuffle, bus.cards_left, bus.deal_card});
        end
        release_reset();
        for (int i = 0; i < 51; i++) do_cycle(0, 1, (i * 7) % 52, 0);
        checks++;
        if (bus.deck_ready !== 1'b0) begin
            errors++; $display("FAIL reload_51 ready=%b exp 0", bus.deck_ready);
        end
        do_cycle(0, 1, 51 * 7 % 52, 0);
        checks++;
        if (bus.deck_ready !== 1'b1) begin
            errors++; $display("FAIL reload_52 ready=%b exp 1", bus.deck_ready);
        end
    endtask

    task automatic test_load_check();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 5, 0);
        checks++;
        if (bus.load_error !== 1'b0) begin
            errors++; $display("FAIL first_5 err=%b exp 0", bus.load_error);
        end
        do_cycle(0, 1, 5, 0);
`ifdef DEALER_DUP_CHECK_EN
        checks++;
        if (bus.load_error !== 1'b1) begin
            errors++; $display("FAIL dup_5 err=%b exp 1", bus.load_error);
        end
        do_cycle(0, 1, 60, 0);
        for (int c = 0; c < 52; c++) begin
            if (c != 5) begin
                do_cycle(0, 1, c, 0);
                if (c == 50) begin
                    checks++;
                    if (bus.deck_ready !== 1'b0) begin
                        errors++; $display("FAIL dup_51_good ready=%b exp 0", bus.deck_ready);
                    end
                end
            end
        end
        checks++;
        if (bus.deck_ready !== 1'b1 || bus.load_error !== 1'b1) begin
            errors++; $display("FAIL dup_52_good ready=%b err=%b exp 1/1", bus.deck_ready, bus.load_error);
        end
`else
        checks++;
        if (bus.load_error !== 1'b0) begin
            errors++; $display("FAIL unchecked_dup err=%b exp 0", bus.load_error);
        end
        for (int i = 0; i < 50; i++) do_cycle(0, 1, i, 0);
        do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 0, 1);
        checks++;
        if (bus.deal_card !== 6'd5 || e_card !== 6'd5) begin
            errors++; $display("FAIL unchecked_store card=%0d exp 5", bus.deal_card);
        end
`endif
        do_cycle(1, 0, 0, 0);
        checks++;
        if (bus.load_error !== 1'b0) begin
            errors++; $display("FAIL err_clear err=%b exp 0", bus.load_error);
        end
    endtask

    task automatic test_random();
        bit nd, lv, dr;
        int lc;
        do_cycle(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            nd = ($urandom_range(0, 299) == 0);
            lv = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 1) == 1);
            lc = ($urandom_range(0, 19) == 0) ? $urandom_range(52, 63) : $urandom_range(0, 51);
`ifndef DEALER_DUP_CHECK_EN
            if (lc > 51) lc = lc - 52;
`endif
            do_cycle(nd, lv, lc, dr);
            checks++;
            if ({bus.deal_valid, bus.deal_empty, bus.deck_ready, bus.need_shuffle, bus.load_error} !==
                {e_valid, e_empty, exp_ready(), exp_shuffle(), e_err}) begin
                errors++; $display("FAIL rand_flags cyc %0d got %b exp %b", n,
                    {bus.deal_valid, bus.deal_empty, bus.deck_ready, bus.need_shuffle, bus.load_error},
                    {e_valid, e_empty, exp_ready(), exp_shuffle(), e_err});
            end
            checks++;
            if (bus.cards_left !== exp_left()) begin
                errors++; $display("FAIL rand_left cyc %0d got %0d exp %0d", n, bus.cards_left, exp_left());
            end
            checks++;
            if ({bus.deal_card, bus.deal_rank, bus.deal_suit, bus.deal_points} !== {e_card, e_rank, e_suit, e_points}) begin
                errors++; $display("FAIL rand_data cyc %0d got c%0d r%0d s%0d p%0d exp c%0d r%0d s%0d p%0d", n,
                    bus.deal_card, bus.deal_rank, bus.deal_suit, bus.deal_points, e_card, e_rank, e_suit, e_points);
            end
        end
    endtask

    initial begin
        bus.new_deck = 0; bus.load_valid = 0; bus.load_card = 0; bus.deal_req = 0;
        model_reset();
        test_reset();
        test_ordered_deal();
        test_threshold();
        test_new_deck_mid_deal();
        test_reset_mid_load();
        test_load_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
